debug_msg_streamer: RTL and testbench
=====================================

DEBUG_MSG_STREAMER -- requirements
Module: debug_msg_streamer

Interface
REQ-001 Parameter NUM_BYTES, default 16: payload byte count, legal range 1..256.
REQ-002 Parameter GAP_CYCLES, default 16: idle clk cycles after each accepted byte, legal range 0..65535.
REQ-003 Parameter HDR_EN, default 1: 1 prepends 5-byte header "DBG: " (0x44 0x42 0x47 0x3A 0x20).
REQ-004 Parameter EOL_EN, default 1: 1 appends 0x0D 0x0A after the payload.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 trigger  input  1  asynchronous button level; a rising edge requests one message.
REQ-008 start_value  input  8  first payload byte, sampled on trigger acceptance.
REQ-009 abort  input  1  synchronous request to end the message early.
REQ-010 tx_ready  input  1  UART TX can accept a byte this cycle.
REQ-011 tx_valid  output  1  tx_data is valid.
REQ-012 tx_data  output  8  byte offered to the UART TX.
REQ-013 busy  output  1  message in progress.
REQ-014 done  output  1  one-cycle pulse at message end, whether complete or aborted.
REQ-015 aborted  output  1  high together with done when the message was cut short.

Function
REQ-016 trigger SHALL pass through a 3-flop synchronizer; the edge equals sync[2] & ~prev.
REQ-017 FSM states SHALL be IDLE, SEND, GAP, FINISH.
REQ-018 IDLE: on edge, latch start_value, clear byte index, and go to SEND on the next cycle with busy=1.
REQ-019 Edges while busy=1 SHALL be ignored, with no queueing.
REQ-020 Byte order SHALL be header (if HDR_EN), then payload byte i = (start_value + i) mod 256, then CR LF (if EOL_EN).
REQ-021 SEND: tx_valid=1; tx_data SHALL stay stable until the cycle where tx_valid & tx_ready.
REQ-022 Once asserted, tx_valid SHALL NOT deassert before acceptance.
REQ-023 On acceptance of a non-last byte: go to GAP, or straight to SEND for the next byte if GAP_CYCLES=0.
REQ-024 On acceptance of the last byte: go to FINISH.
REQ-025 GAP: count GAP_CYCLES cycles with tx_valid=0, then go to SEND.
REQ-026 FINISH: done=1 for exactly one cycle, busy=0 on the next cycle, return to IDLE.
REQ-027 Abort in GAP SHALL go to FINISH on the next cycle with aborted=1.
REQ-028 Abort in SEND SHALL complete the pending byte handshake, then go to FINISH with aborted=1.
REQ-029 Abort held through a cycle with an accepted byte SHALL cancel the remaining bytes.
REQ-030 Abort in IDLE SHALL have no effect.
REQ-031 Total bytes = 5*HDR_EN + NUM_BYTES + 2*EOL_EN.
REQ-032 The byte index SHALL be 10 bits wide; payload arithmetic wraps at 8 bits (0xFF+1 = 0x00).
REQ-033 The gap counter SHALL be 16 bits wide.
REQ-034 Minimum latency SHALL be: trigger edge to tx_valid = 3 (sync) + 1 (edge) + 1 (IDLE) cycles.

Reset
REQ-035 While reset=1: state=IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0, aborted=0, counters=0, synchronizer=0.
REQ-036 Reset mid-message SHALL drop tx_valid on the next edge, override the handshake rule, and emit no done.

Structure
REQ-037 The shared package SHALL hold the FSM state enum, the header byte constants, and the CR/LF constants.
REQ-038 One sub-module, sync_edge_det (synchronizer plus rising-edge detector), SHALL be instantiated for trigger.
REQ-039 All other logic SHALL reside in debug_msg_streamer.

Verification
REQ-040 Defaults, tx_ready=1, start_value=0x00, one trigger -> 23 bytes "DBG: " 00..0F 0D 0A, 16-cycle gaps, one done, aborted=0.
REQ-041 NUM_BYTES=4, HDR_EN=0, EOL_EN=0, start_value=0xFE -> bytes FE FF 00 01, then done.
REQ-042 tx_ready low 10 cycles on byte 3 -> tx_valid held and tx_data stable 10 cycles; no byte lost or duplicated.
REQ-043 Second trigger edge during GAP -> ignored; exactly one message sent.
REQ-044 Abort during SEND of byte 7 with tx_ready=0, then tx_ready=1 -> byte 7 accepted, then done and aborted pulse together; no byte 8.
REQ-045 Reset asserted in GAP after byte 4 -> all outputs at reset values; a new trigger sends a full message.

Source files
------------

// File: rtl/debug_msg_streamer_pkg.sv
// Shared definitions for debug_msg_streamer.
//   state_e        : message FSM states
//   HDR_* / CR/LF  : fixed bytes framing each message
//   hdr_byte()     : header byte lookup by position
package debug_msg_streamer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSend   = 2'd1,
    StGap    = 2'd2,
    StFinish = 2'd3
  } state_e;

  localparam int unsigned HDR_LEN = 5;

  // "DBG: "
  localparam logic [7:0] HDR_B0 = 8'h44;
  localparam logic [7:0] HDR_B1 = 8'h42;
  localparam logic [7:0] HDR_B2 = 8'h47;
  localparam logic [7:0] HDR_B3 = 8'h3A;
  localparam logic [7:0] HDR_B4 = 8'h20;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HDR_B0;
      3'd1:    b = HDR_B1;
      3'd2:    b = HDR_B2;
      3'd3:    b = HDR_B3;
      3'd4:    b = HDR_B4;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer followed by a rising-edge detector.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset (clears the synchronizer)
//   i_async : asynchronous input level
//   o_edge  : one-cycle pulse on a synchronized 0->1 transition
module sync_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_edge
);

  logic [2:0] r_sync;
  logic       r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= 3'b000;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
      r_prev <= r_sync[2];
    end
  end

  assign o_edge = r_sync[2] & ~r_prev;

endmodule

// File: rtl/debug_msg_streamer.sv
// Streams one debug message per trigger edge to a UART TX byte interface:
// optional "DBG: " header, NUM_BYTES incrementing payload bytes, optional CR LF,
// with GAP_CYCLES idle cycles after each accepted byte.
//   clk, reset          : system clock, synchronous active-high reset
//   trigger             : asynchronous button level, rising edge starts a message
//   start_value         : first payload byte, captured when the message starts
//   abort               : end the current message early
//   tx_ready            : UART can take a byte this cycle
//   tx_valid, tx_data   : byte offer to the UART
//   busy, done, aborted : message status
module debug_msg_streamer
  import debug_msg_streamer_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 16,
  parameter int unsigned GAP_CYCLES = 16,
  parameter bit          HDR_EN     = 1'b1,
  parameter bit          EOL_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] start_value,
  input  logic       abort,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int unsigned HdrLen     = HDR_EN ? HDR_LEN : 0;
  localparam int unsigned EolLen     = EOL_EN ? 2 : 0;
  localparam int unsigned TotalBytes = HdrLen + NUM_BYTES + EolLen;

  localparam logic [9:0]  LastIdx   = 10'(TotalBytes - 1);
  localparam logic [9:0]  HdrLenW   = 10'(HdrLen);
  localparam logic [9:0]  NumBytesW = 10'(NUM_BYTES);
  localparam bit          GapEn     = (GAP_CYCLES != 0);
  localparam logic [15:0] GapLast   = GapEn ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_e      r_state;
  logic [9:0]  r_idx;
  logic [7:0]  r_start;
  logic [15:0] r_gap;
  logic        r_abort_pend;
  logic        r_aborted;

  state_e      w_state_nxt;
  logic [9:0]  w_idx_nxt;
  logic [7:0]  w_start_nxt;
  logic [15:0] w_gap_nxt;
  logic        w_abort_pend_nxt;
  logic        w_aborted_nxt;

  logic        w_edge;
  logic [9:0]  w_pay_idx;
  logic [7:0]  w_byte;
  logic        w_last;

  sync_edge_det u_sync_edge_det (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (trigger),
    .o_edge  (w_edge)
  );

  // Byte selection from the message index.
  assign w_pay_idx = r_idx - HdrLenW;
  assign w_last    = (r_idx == LastIdx);

  always_comb begin
    w_byte = 8'h00;
    if (HDR_EN && (r_idx < HdrLenW)) begin
      w_byte = hdr_byte(r_idx[2:0]);
    end else if (w_pay_idx < NumBytesW) begin
      w_byte = r_start + w_pay_idx[7:0];  // wraps at 8 bits
    end else if (w_pay_idx == NumBytesW) begin
      w_byte = CHAR_CR;
    end else begin
      w_byte = CHAR_LF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_idx        <= 10'd0;
      r_start      <= 8'h00;
      r_gap        <= 16'd0;
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_start      <= w_start_nxt;
      r_gap        <= w_gap_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_start_nxt      = r_start;
    w_gap_nxt        = r_gap;
    w_abort_pend_nxt = r_abort_pend;
    w_aborted_nxt    = r_aborted;

    unique case (r_state)
      StIdle: begin
        w_abort_pend_nxt = 1'b0;
        w_aborted_nxt    = 1'b0;
        if (w_edge) begin
          w_start_nxt = start_value;
          w_idx_nxt   = 10'd0;
          w_gap_nxt   = 16'd0;
          w_state_nxt = StSend;
        end
      end

      StSend: begin
        // An abort seen while the UART stalls is remembered; the pending byte
        // still completes its handshake before the message ends.
        if (abort) begin
          w_abort_pend_nxt = 1'b1;
        end
        if (tx_ready) begin
          if (w_last) begin
            w_aborted_nxt = 1'b0;
            w_state_nxt   = StFinish;
          end else if (abort || r_abort_pend) begin
            w_aborted_nxt = 1'b1;
            w_state_nxt   = StFinish;
          end else begin
            w_idx_nxt   = r_idx + 10'd1;
            w_gap_nxt   = 16'd0;
            w_state_nxt = GapEn ? StGap : StSend;
          end
        end
      end

      StGap: begin
        if (abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = StFinish;
        end else if (r_gap == GapLast) begin
          w_state_nxt = StSend;
        end else begin
          w_gap_nxt = r_gap + 16'd1;
        end
      end

      StFinish: begin
        w_abort_pend_nxt = 1'b0;
        w_state_nxt      = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Outputs decode straight from registered state, so reset forces them at once.
  assign tx_valid = (r_state == StSend);
  assign tx_data  = tx_valid ? w_byte : 8'h00;
  assign busy     = (r_state != StIdle);
  assign done     = (r_state == StFinish);
  assign aborted  = done & r_aborted;

endmodule

// File: tb/tb_debug_msg_streamer.sv
module tb_debug_msg_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic       trig_a, abort_a, ready_a;
  logic [7:0] start_a;
  logic       valid_a, busy_a, done_a, aborted_a;
  logic [7:0] data_a;

  // DUT B: 4 payload bytes, no header, no EOL, short gap
  logic       trig_b, abort_b, ready_b;
  logic [7:0] start_b;
  logic       valid_b, busy_b, done_b, aborted_b;
  logic [7:0] data_b;

  debug_msg_streamer u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trig_a),
    .start_value (start_a),
    .abort       (abort_a),
    .tx_ready    (ready_a),
    .tx_valid    (valid_a),
    .tx_data     (data_a),
    .busy        (busy_a),
    .done        (done_a),
    .aborted     (aborted_a)
  );

  debug_msg_streamer #(
    .NUM_BYTES  (4),
    .GAP_CYCLES (2),
    .HDR_EN     (1'b0),
    .EOL_EN     (1'b0)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trig_b),
    .start_value (start_b),
    .abort       (abort_b),
    .tx_ready    (ready_b),
    .tx_valid    (valid_b),
    .tx_data     (data_b),
    .busy        (busy_b),
    .done        (done_b),
    .aborted     (aborted_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: handshakes complete at the posedge following a negedge that sees
  // valid & ready, since inputs only change just after a posedge.
  logic [7:0] qa[$];
  int         acc_cyc_a[$];
  logic [7:0] qb[$];
  int cyc          = 0;
  int done_a_cnt   = 0;
  int abrt_a_cnt   = 0;
  int stray_abrt_a = 0;
  int hold_viol_a  = 0;
  int done_b_cnt   = 0;
  int abrt_b_cnt   = 0;

  initial begin
    logic       hold_a;
    logic [7:0] hold_data_a;
    hold_a      = 1'b0;
    hold_data_a = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold_a = 1'b0;
      end else begin
        if (hold_a && (!valid_a || data_a !== hold_data_a)) hold_viol_a++;
        hold_a      = valid_a && !ready_a;
        hold_data_a = data_a;
        if (valid_a && ready_a) begin
          qa.push_back(data_a);
          acc_cyc_a.push_back(cyc);
        end
        if (done_a) begin
          done_a_cnt++;
          if (aborted_a) abrt_a_cnt++;
        end
        if (aborted_a && !done_a) stray_abrt_a++;
        if (valid_b && ready_b) qb.push_back(data_b);
        if (done_b) done_b_cnt++;
        if (aborted_b) abrt_b_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent model of the default message.
  function automatic logic [7:0] exp_a(input logic [7:0] sv, input int i);
    logic [7:0] b;
    case (i)
      0:       b = 8'h44;
      1:       b = 8'h42;
      2:       b = 8'h47;
      3:       b = 8'h3A;
      4:       b = 8'h20;
      21:      b = 8'h0D;
      22:      b = 8'h0A;
      default: b = sv + 8'(i - 5);
    endcase
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_a(input logic [7:0] sv);
    start_a = sv;
    trig_a  = 1'b1;
    repeat (6) tick();
    trig_a  = 1'b0;
  endtask

  task automatic wait_qa(input int n, input int budget, input string name);
    int k = 0;
    while (qa.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(qa.size() >= n), 32'd1);
  endtask

  task automatic wait_done_a(input int base, input int budget, input string name);
    int k = 0;
    while (done_a_cnt <= base && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(done_a_cnt > base), 32'd1);
  endtask

  task automatic check_msg_a(input int base, input logic [7:0] sv, input string name);
    int bad = 0;
    check({name, "_len"}, 32'(qa.size() - base), 32'd23);
    for (int i = 0; i < 23 && base + i < qa.size(); i++) begin
      if (qa[base + i] !== exp_a(sv, i)) bad++;
    end
    check({name, "_bytes_bad"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0] sv;
    int         idx;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] starts[3];
  logic [7:0] exp_b[4];

  initial begin
    int base, bd, ba, k, bad;

    tbl[0]  = '{8'h00, 0,  8'h44};
    tbl[1]  = '{8'h00, 4,  8'h20};
    tbl[2]  = '{8'h00, 5,  8'h00};
    tbl[3]  = '{8'h00, 20, 8'h0F};
    tbl[4]  = '{8'h00, 21, 8'h0D};
    tbl[5]  = '{8'h00, 22, 8'h0A};
    tbl[6]  = '{8'h7F, 5,  8'h7F};
    tbl[7]  = '{8'h7F, 6,  8'h80};
    tbl[8]  = '{8'hF5, 15, 8'hFF};
    tbl[9]  = '{8'hF5, 16, 8'h00};
    tbl[10] = '{8'hF5, 20, 8'h04};
    tbl[11] = '{8'hF5, 3,  8'h3A};
    starts[0] = 8'h00;
    starts[1] = 8'h7F;
    starts[2] = 8'hF5;
    exp_b[0] = 8'hFE;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h00;
    exp_b[3] = 8'h01;

    reset   = 1'b1;
    trig_a  = 1'b0; abort_a = 1'b0; ready_a = 1'b1; start_a = 8'h00;
    trig_b  = 1'b0; abort_b = 1'b0; ready_b = 1'b1; start_b = 8'h00;
    repeat (3) tick();

    check("rst_tx_valid", 32'(valid_a), 32'd0);
    check("rst_tx_data", 32'(data_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_aborted", 32'(aborted_a), 32'd0);

    reset = 1'b0;
    tick();

    // Abort in idle must not start or disturb anything.
    abort_a = 1'b1;
    repeat (5) tick();
    abort_a = 1'b0;
    check("idle_abort_busy", 32'(busy_a), 32'd0);

    // Full default messages, bytes checked against the vector table.
    for (int s = 0; s < 3; s++) begin
      base = qa.size();
      bd   = done_a_cnt;
      ba   = abrt_a_cnt;
      fire_a(starts[s]);
      wait_done_a(bd, 1000, "full_done_timeout");
      repeat (3) tick();
      check_msg_a(base, starts[s], "full_msg");
      check("full_done_cnt", 32'(done_a_cnt - bd), 32'd1);
      check("full_aborted_cnt", 32'(abrt_a_cnt - ba), 32'd0);
      check("full_busy_after", 32'(busy_a), 32'd0);
      for (int t = 0; t < 12; t++) begin
        if (tbl[t].sv == starts[s] && base + tbl[t].idx < qa.size()) begin
          check($sformatf("tbl_sv%0h_idx%0d", tbl[t].sv, tbl[t].idx),
                32'(qa[base + tbl[t].idx]), 32'(tbl[t].exp));
        end
      end
      if (s == 0) begin
        bad = 0;
        for (int i = base + 1; i < base + 23 && i < acc_cyc_a.size(); i++) begin
          if (acc_cyc_a[i] - acc_cyc_a[i - 1] != 17) bad++;
        end
        check("gap_spacing_bad", 32'(bad), 32'd0);
      end
    end

    // Small configuration with payload wrap.
    base = qb.size();
    bd   = done_b_cnt;
    start_b = 8'hFE;
    trig_b  = 1'b1;
    repeat (6) tick();
    trig_b  = 1'b0;
    k = 0;
    while (done_b_cnt == bd && k < 200) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check("b_done_cnt", 32'(done_b_cnt - bd), 32'd1);
    check("b_len", 32'(qb.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < qb.size(); i++) begin
      check($sformatf("b_byte%0d", i), 32'(qb[base + i]), 32'(exp_b[i]));
    end
    check("b_busy_after", 32'(busy_b), 32'd0);

    // Back-pressure on byte 3.
    base = qa.size();
    bd   = done_a_cnt;
    fire_a(8'h10);
    wait_qa(base + 3, 200, "bp_wait_byte2");
    ready_a = 1'b0;
    k = 0;
    while (!valid_a && k < 40) begin
      tick();
      k++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!valid_a || data_a !== 8'h3A) bad++;
      tick();
    end
    check("bp_hold_bad", 32'(bad), 32'd0);
    ready_a = 1'b1;
    wait_done_a(bd, 1000, "bp_done_timeout");
    repeat (3) tick();
    check_msg_a(base, 8'h10, "bp_msg");

    // Second trigger edge during GAP is ignored.
    base = qa.size();
    bd   = done_a_cnt;
    fire_a(8'h20);
    wait_qa(base + 2, 200, "retrig_wait");
    fire_a(8'h55);
    wait_done_a(bd, 1000, "retrig_done_timeout");
    repeat (100) tick();
    check_msg_a(base, 8'h20, "retrig_msg");
    check("retrig_done_cnt", 32'(done_a_cnt - bd), 32'd1);

    // Abort while byte 7 is stalled.
    base = qa.size();
    bd   = done_a_cnt;
    ba   = abrt_a_cnt;
    fire_a(8'h40);
    wait_qa(base + 7, 300, "abort_wait_byte6");
    ready_a = 1'b0;
    k = 0;
    while (!valid_a && k < 40) begin
      tick();
      k++;
    end
    check("abort_pending_byte", 32'(data_a), 32'h42);
    abort_a = 1'b1;
    repeat (3) tick();
    ready_a = 1'b1;
    tick();
    abort_a = 1'b0;
    wait_done_a(bd, 50, "abort_done_timeout");
    repeat (60) tick();
    check("abort_len", 32'(qa.size() - base), 32'd8);
    check("abort_last_byte", 32'(qa[qa.size() - 1]), 32'h42);
    check("abort_done_cnt", 32'(done_a_cnt - bd), 32'd1);
    check("abort_aborted_cnt", 32'(abrt_a_cnt - ba), 32'd1);
    check("abort_busy_after", 32'(busy_a), 32'd0);

    // Reset in GAP after byte 4, then a fresh message.
    base = qa.size();
    bd   = done_a_cnt;
    fire_a(8'h30);
    wait_qa(base + 5, 300, "rst_wait_byte4");
    reset = 1'b1;
    tick();
    check("midrst_tx_valid", 32'(valid_a), 32'd0);
    check("midrst_tx_data", 32'(data_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    check("midrst_aborted", 32'(aborted_a), 32'd0);
    reset = 1'b0;
    repeat (30) tick();
    check("midrst_no_done", 32'(done_a_cnt - bd), 32'd0);
    check("midrst_len", 32'(qa.size() - base), 32'd5);
    base = qa.size();
    bd   = done_a_cnt;
    fire_a(8'h30);
    wait_done_a(bd, 1000, "postrst_done_timeout");
    repeat (3) tick();
    check_msg_a(base, 8'h30, "postrst_msg");

    check("hold_violations", 32'(hold_viol_a), 32'd0);
    check("stray_aborted", 32'(stray_abrt_a), 32'd0);
    check("b_aborted_cnt", 32'(abrt_b_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
